shared_ram_responder: RTL and testbench

Memory-side responder for the multi-core processor: accepts independent per-core read/write requests from up to NO_OF_CORES cores, serialises them with a round-robin arbiter onto one internal single-port RAM, and returns read data plus a one-cycle acknowledge to each requester. It sits between the core array and the data memory. It replaces the lock-step shared bus, where one combined read/write strobe served all cores, with a per-core request/acknowledge handshake.

---
 rtl/mem_if_pkg.sv | 24 ++
 rtl/shared_ram_responder_rr_arbiter.sv | 30 +++
 rtl/shared_ram_responder.sv | 137 +++++++++++++
 tb/tb_shared_ram_responder.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_if_pkg.sv
// Shared types and default sizes for the core-to-memory request interface.
package mem_if_pkg;

  localparam int unsigned DATA_LEN_DEF    = 16;
  localparam int unsigned ADDRESS_LEN_DEF = 12;
  localparam int unsigned NO_OF_CORES_DEF = 6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  // Width of a core index; at least one bit even for a single core.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/shared_ram_responder_rr_arbiter.sv
// Round-robin arbiter: first set request at or above ptr, wrapping past the top core.
module rr_arbiter
  import mem_if_pkg::*;
#(
  parameter  int unsigned NO_OF_CORES = NO_OF_CORES_DEF,
  localparam int unsigned IDX_W       = idx_width(NO_OF_CORES)
) (
  input  logic [NO_OF_CORES-1:0] req,
  input  logic [IDX_W-1:0]       ptr,
  output logic [IDX_W-1:0]       grant_idx,
  output logic                   grant_valid
);

  // Scan cores in priority order starting at ptr; the first hit wins.
  always_comb begin
    int unsigned k;
    k           = 0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int unsigned i = 0; i < NO_OF_CORES; i++) begin
      k = 32'(ptr) + i;
      if (k >= NO_OF_CORES) k = k - NO_OF_CORES;
      if (!grant_valid && req[k[IDX_W-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = k[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/shared_ram_responder.sv
// Memory-side responder: arbitrates per-core read/write requests onto one
// single-port RAM and returns read data with a one-cycle per-core ack.
module shared_ram_responder
  import mem_if_pkg::*;
#(
  parameter int unsigned DATA_LEN    = DATA_LEN_DEF,
  parameter int unsigned ADDRESS_LEN = ADDRESS_LEN_DEF,
  parameter int unsigned NO_OF_CORES = NO_OF_CORES_DEF,
  parameter              INIT_FILE   = ""
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NO_OF_CORES-1:0]          read_req,
  input  logic [NO_OF_CORES-1:0]          write_req,
  input  logic [ADDRESS_LEN*NO_OF_CORES-1:0] address,
  input  logic [DATA_LEN*NO_OF_CORES-1:0] wr_data,
  output logic [DATA_LEN*NO_OF_CORES-1:0] rd_data,
  output logic [NO_OF_CORES-1:0]          ack,
  output logic                            busy
);

  localparam int unsigned IDX_W = idx_width(NO_OF_CORES);
  localparam int unsigned DEPTH = 1 << ADDRESS_LEN;

  logic [DATA_LEN-1:0] mem [0:DEPTH-1];

  state_e                          state_q, state_d;
  op_e                             op_q, op_d;
  logic [IDX_W-1:0]                ptr_q, ptr_d;
  logic [IDX_W-1:0]                g_q, g_d;
  logic [ADDRESS_LEN-1:0]          addr_q, addr_d;
  logic [DATA_LEN-1:0]             wdata_q, wdata_d;
  logic [DATA_LEN*NO_OF_CORES-1:0] rd_data_q, rd_data_d;
  logic [NO_OF_CORES-1:0]          ack_q, ack_d;
  logic                            busy_q, busy_d;

  logic [NO_OF_CORES-1:0] req;
  logic [IDX_W-1:0]       grant_idx;
  logic                   grant_valid;
  logic [ADDRESS_LEN-1:0] grant_addr;
  logic [DATA_LEN-1:0]    grant_wdata;
  logic [ADDRESS_LEN-1:0] ram_addr;
  logic                   ram_we;
  logic [DATA_LEN-1:0]    ram_rdata;

  assign req = read_req | write_req;

  rr_arbiter #(
    .NO_OF_CORES(NO_OF_CORES)
  ) u_arb (
    .req        (req),
    .ptr        (ptr_q),
    .grant_idx  (grant_idx),
    .grant_valid(grant_valid)
  );

  // Select the granted core's address/data slices and drive the RAM port.
  // The read is launched from the live grant address in IDLE so the word is
  // already registered when ACCESS copies it into the core's rd_data slice;
  // the write commits from the latched request at the end of ACCESS.
  always_comb begin
    grant_addr  = address[ADDRESS_LEN*grant_idx +: ADDRESS_LEN];
    grant_wdata = wr_data[DATA_LEN*grant_idx +: DATA_LEN];
    ram_addr    = (state_q == IDLE) ? grant_addr : addr_q;
    ram_we      = (state_q == ACCESS) && (op_q == OP_WRITE) && !reset;
  end

  // Synchronous single-port RAM; contents survive reset, aborted writes are gated.
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= wdata_q;
    ram_rdata <= mem[ram_addr];
  end

  // Next-state logic for the IDLE -> ACCESS -> RESPOND transaction sequence.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    ptr_d     = ptr_q;
    g_d       = g_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rd_data_d = rd_data_q;
    ack_d     = '0;
    unique case (state_q)
      IDLE: begin
        if (grant_valid) begin
          g_d     = grant_idx;
          op_d    = write_req[grant_idx] ? OP_WRITE : OP_READ;
          addr_d  = grant_addr;
          wdata_d = grant_wdata;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (op_q == OP_READ) rd_data_d[DATA_LEN*g_q +: DATA_LEN] = ram_rdata;
        ack_d[g_q] = 1'b1;
        state_d    = RESPOND;
      end
      RESPOND: begin
        ptr_d   = (g_q == IDX_W'(NO_OF_CORES - 1)) ? '0 : g_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Registered FSM state and outputs; reset abandons any transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      op_q      <= OP_READ;
      ptr_q     <= '0;
      g_q       <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_data_q <= '0;
      ack_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      ptr_q     <= ptr_d;
      g_q       <= g_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rd_data_q <= rd_data_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
    end
  end

  assign rd_data = rd_data_q;
  assign ack     = ack_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_shared_ram_responder.sv
// Scoreboard bench for shared_ram_responder: stimulus pushes expected acks,
// a negedge monitor pops and checks them against a per-core rd_data model.
module tb_shared_ram_responder;

  localparam int DL = 16;
  localparam int AL = 12;
  localparam int NC = 6;

  logic             clk;
  logic             reset;
  logic [NC-1:0]    read_req;
  logic [NC-1:0]    write_req;
  logic [AL*NC-1:0] address;
  logic [DL*NC-1:0] wr_data;
  logic [DL*NC-1:0] rd_data;
  logic [NC-1:0]    ack;
  logic             busy;

  shared_ram_responder #(
    .DATA_LEN   (DL),
    .ADDRESS_LEN(AL),
    .NO_OF_CORES(NC),
    .INIT_FILE  ("")
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .read_req (read_req),
    .write_req(write_req),
    .address  (address),
    .wr_data  (wr_data),
    .rd_data  (rd_data),
    .ack      (ack),
    .busy     (busy)
  );

  typedef struct {
    int          core;
    bit          is_read;
    logic [15:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] model_rd [NC];
  int          n_cmp;
  int          n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, required $finish before it");
    $fatal(1);
  end

  // Monitor: every ack must match the next expected entry; rd_data is checked
  // in full against the model so untouched slices are verified too.
  initial begin
    exp_t        e;
    logic [DL*NC-1:0] exp_bus;
    for (int c = 0; c < NC; c++) model_rd[c] = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        for (int c = 0; c < NC; c++) model_rd[c] = '0;
      end else if (ack != '0) begin
        n_cmp++;
        if ($countones(ack) != 1) begin
          n_fail++;
          $display("FAIL ack_onehot: ack=%b, required exactly one bit", ack);
        end
        n_cmp++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_ack: ack=%b, required no ack", ack);
        end else begin
          e = sb.pop_front();
          if (!ack[e.core]) begin
            n_fail++;
            $display("FAIL ack_core: ack=%b, required core %0d", ack, e.core);
          end
          if (e.is_read) model_rd[e.core] = e.data;
          for (int c = 0; c < NC; c++) exp_bus[DL*c +: DL] = model_rd[c];
          n_cmp++;
          if (rd_data !== exp_bus) begin
            n_fail++;
            $display("FAIL rd_data: got %h, required %h", rd_data, exp_bus);
          end
        end
      end
    end
  end

  task automatic push(input int c, input bit is_read, input logic [15:0] d);
    exp_t e;
    e.core = c; e.is_read = is_read; e.data = d;
    sb.push_back(e);
  endtask

  task automatic set_core(input int c, input bit rd, input bit wr,
                          input logic [11:0] a, input logic [15:0] d);
    read_req[c]         = rd;
    write_req[c]        = wr;
    address[AL*c +: AL] = a;
    wr_data[DL*c +: DL] = d;
  endtask

  task automatic check(input string name, input logic [95:0] got, input logic [95:0] req);
    n_cmp++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  // One request from one core, waited on with a bound; checks busy and latency.
  task automatic single(input int c, input bit rd, input bit wr,
                        input logic [11:0] a, input logic [15:0] d,
                        input bit exp_read, input logic [15:0] exp_data);
    int lat;
    bit got;
    push(c, exp_read, exp_data);
    set_core(c, rd, wr, a, d);
    lat = 0; got = 0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (lat == 1) check("busy_access", 96'(busy), 96'd1);
      if (ack[c]) got = 1;
    end
    check("ack_latency", 96'(got ? lat : -1), 96'd2);
    set_core(c, 0, 0, a, d);
    @(negedge clk);
    check("busy_idle", 96'(busy), 96'd0);
  endtask

  // Run for up to `cycles`, counting acks and checking 3-cycle spacing.
  task automatic run_window(input string name, input int cycles, input int exp_acks,
                            input bit release_on_ack);
    int got, last;
    got = 0; last = -1;
    for (int i = 1; i <= cycles; i++) begin
      @(negedge clk);
      if (ack != '0) begin
        got++;
        if (got == 1) check({name, "_first_lat"}, 96'(i), 96'd2);
        else          check({name, "_spacing"}, 96'(i - last), 96'd3);
        last = i;
        if (release_on_ack)
          for (int c = 0; c < NC; c++) if (ack[c]) set_core(c, 0, 0, '0, '0);
      end
      if (release_on_ack && got == exp_acks) break;
    end
    check({name, "_ack_count"}, 96'(got), 96'(exp_acks));
    read_req = '0; write_req = '0;
    @(negedge clk);
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    reset = 1'b1; read_req = '0; write_req = '0; address = '0; wr_data = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_ack", 96'(ack), 96'd0);
    check("reset_busy", 96'(busy), 96'd0);
    check("reset_rd_data", 96'(rd_data), 96'd0);

    // Core 2 write then read back (ptr -> 3).
    single(2, 0, 1, 12'd5, 16'hBEEF, 0, 16'h0);
    single(2, 1, 0, 12'd5, 16'h0000, 1, 16'hBEEF);

    // Preload: core c writes C000+c to 200+c; ends with ptr = 0.
    for (int c = 0; c < NC; c++) single(c, 0, 1, 12'(200 + c), 16'(16'hC000 + c), 0, 16'h0);
    single(0, 0, 1, 12'd100, 16'h1111, 0, 16'h0);
    single(0, 0, 1, 12'd103, 16'h3333, 0, 16'h0);
    single(0, 0, 1, 12'd105, 16'h5555, 0, 16'h0);
    single(5, 0, 1, 12'd7,   16'h0777, 0, 16'h0);

    // Cores 0, 3, 5 read together from ptr = 0.
    push(0, 1, 16'h1111); push(3, 1, 16'h3333); push(5, 1, 16'h5555);
    set_core(0, 1, 0, 12'd100, '0);
    set_core(3, 1, 0, 12'd103, '0);
    set_core(5, 1, 0, 12'd105, '0);
    run_window("rr3", 30, 3, 1);

    // Core 5 was last: ptr wraps to 0, so core 0 precedes core 5.
    push(0, 1, 16'h3333); push(5, 1, 16'h1111);
    set_core(0, 1, 0, 12'd103, '0);
    set_core(5, 1, 0, 12'd100, '0);
    run_window("wrap", 20, 2, 1);

    // Core 1 gets a nonzero slice, then read+write together acts as a write.
    single(1, 1, 0, 12'd105, 16'h0, 1, 16'h5555);
    single(1, 1, 1, 12'd23, 16'h1234, 0, 16'h0);

    // Reset during ACCESS of core 4's write; ptr was 2 beforehand.
    set_core(4, 0, 1, 12'd7, 16'hAAAA);
    @(negedge clk);
    check("abort_busy", 96'(busy), 96'd1);
    reset = 1'b1;
    set_core(4, 0, 0, '0, '0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("abort_ack", 96'(ack), 96'd0);
    check("abort_busy_idle", 96'(busy), 96'd0);
    check("abort_rd_data", 96'(rd_data), 96'd0);
    repeat (4) @(negedge clk);

    // ptr back at 0: core 1 before core 4; addr 7 kept, addr 23 holds 1234.
    push(1, 1, 16'h0777); push(4, 1, 16'h1234);
    set_core(1, 1, 0, 12'd7, '0);
    set_core(4, 1, 0, 12'd23, '0);
    run_window("post_reset", 20, 2, 1);

    // All cores request continuously; ptr starts at 5.
    for (int j = 0; j < 12; j++) push((5 + j) % NC, 1, 16'(16'hC000 + ((5 + j) % NC)));
    for (int c = 0; c < NC; c++) set_core(c, 1, 0, 12'(200 + c), '0);
    run_window("all6", 36, 12, 0);
    repeat (4) @(negedge clk);

    check("scoreboard_empty", 96'(sb.size()), 96'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
